// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the synchronous FIFO core and its storage array.
package fifo_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned ADD_WIDTH_DEF  = 4;

    // Number of stored words for a given address width.
    function automatic int unsigned fifo_depth(input int unsigned add_width);
        return 32'(1) << add_width;
    endfunction

    // Pointer width: address bits plus one wrap bit to tell full from empty.
    function automatic int unsigned ptr_w(input int unsigned add_width);
        return add_width + 32'(1);
    endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// Simple dual-port storage array: synchronous write, asynchronous read address.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADD_WIDTH  = ADD_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADD_WIDTH-1:0]  i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADD_WIDTH-1:0]  i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data_c
);

    localparam int unsigned DEPTH = fifo_depth(ADD_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port presents the pre-edge word; the core registers it.
    assign o_rd_data_c = r_mem[i_rd_addr];

endmodule : fifo_mem

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO: wrap-bit pointers, full/empty flags and registered read data.
module sync_fifo_core
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADD_WIDTH  = ADD_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  fifo_full,
    output logic                  fifo_empty
);

    localparam int unsigned PTR_W = ptr_w(ADD_WIDTH);

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_accept;
    logic                  w_rd_accept;

    // Flags come straight from the registered pointers.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                     (r_wr_ptr[ADD_WIDTH-1:0] == r_rd_ptr[ADD_WIDTH-1:0]);

    // Both qualifiers use pre-edge flags, so a full FIFO rejects a same-cycle write.
    assign w_wr_accept = wr_en && !w_full;
    assign w_rd_accept = rd_en && !w_empty;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADD_WIDTH  (ADD_WIDTH)
    ) u_mem (
        .clk         (clk),
        .i_wr_en     (w_wr_accept),
        .i_wr_addr   (r_wr_ptr[ADD_WIDTH-1:0]),
        .i_wr_data   (data_in),
        .i_rd_addr   (r_rd_ptr[ADD_WIDTH-1:0]),
        .o_rd_data_c (w_rd_data)
    );

    // Pointer advance; natural wrap at 2**PTR_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Read data register; holds its value when no read is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_out <= '0;
        end else if (w_rd_accept) begin
            r_data_out <= w_rd_data;
        end
    end

    assign data_out   = r_data_out;
    assign fifo_full  = w_full;
    assign fifo_empty = w_empty;

endmodule : sync_fifo_core

// File: tb/tb_sync_fifo_core.sv
// Directed bench for sync_fifo_core with hand-computed expectations.
module tb_sync_fifo_core;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] data_in;
    logic       rd_en;
    logic [7:0] data_out;
    logic       fifo_full;
    logic       fifo_empty;

    int n_checks;
    int n_errors;

    sync_fifo_core #(
        .DATA_WIDTH (8),
        .ADD_WIDTH  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .data_in    (data_in),
        .rd_en      (rd_en),
        .data_out   (data_out),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hard stop if the run ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        data_in  = 8'h00;
        #1;
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_full",  32'(fifo_full),  32'd0);
        chk("rst_dout",  32'(data_out),   32'h00);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Mid-run reset with 5 words stored.
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            data_in = 8'(8'h51 + i);
            tick();
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("pre_rst_dout",  32'(data_out),   32'h51);
        chk("pre_rst_empty", 32'(fifo_empty), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_empty", 32'(fifo_empty), 32'd1);
        chk("async_rst_full",  32'(fifo_full),  32'd0);
        chk("async_rst_dout",  32'(data_out),   32'h00);
        chk("async_rst_wptr",  32'(dut.r_wr_ptr), 32'd0);
        #1;
        rst = 1'b0;
        tick();

        // Fill with 0x01..0x10.
        for (int i = 1; i <= 16; i++) begin
            wr_en   = 1'b1;
            data_in = 8'(i);
            tick();
            if (i == 15) chk("fill15_full", 32'(fifo_full), 32'd0);
        end
        chk("fill16_full",  32'(fifo_full),  32'd1);
        chk("fill16_empty", 32'(fifo_empty), 32'd0);
        data_in = 8'hAA;
        tick();
        wr_en = 1'b0;
        chk("over_full", 32'(fifo_full),     32'd1);
        chk("over_wptr", 32'(dut.r_wr_ptr),  32'd16);

        // Drain 16 in order.
        rd_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("drain_%0d", i), 32'(data_out), 32'(i));
        end
        rd_en = 1'b0;
        chk("drain_empty", 32'(fifo_empty), 32'd1);

        // Reads while empty are ignored.
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("under_empty", 32'(fifo_empty), 32'd1);
            chk("under_dout",  32'(data_out),   32'h10);
        end
        rd_en = 1'b0;
        chk("under_rptr", 32'(dut.r_rd_ptr), 32'd16);
        chk("under_wptr", 32'(dut.r_wr_ptr), 32'd16);

        // Store 8, then 20 simultaneous cycles across the pointer wrap.
        for (int i = 0; i < 8; i++) begin
            wr_en   = 1'b1;
            data_in = 8'(8'h20 + i);
            tick();
        end
        rd_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            data_in = 8'(8'h28 + k);
            tick();
            chk($sformatf("stream_%0d", k), 32'(data_out), 32'(8'h20 + k));
            chk("stream_full", 32'(fifo_full), 32'd0);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("stream_wptr", 32'(dut.r_wr_ptr), 32'd12);
        chk("stream_rptr", 32'(dut.r_rd_ptr), 32'd4);
        rd_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("stream_tail_%0d", k), 32'(data_out), 32'(8'h34 + k));
        end
        rd_en = 1'b0;
        chk("stream_empty", 32'(fifo_empty), 32'd1);

        // Full with simultaneous read and write: write is dropped.
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            data_in = 8'(8'h60 + i);
            tick();
        end
        chk("full2_full", 32'(fifo_full), 32'd1);
        rd_en   = 1'b1;
        data_in = 8'hEE;
        tick();
        wr_en = 1'b0;
        chk("fullrw_dout", 32'(data_out),  32'h60);
        chk("fullrw_full", 32'(fifo_full), 32'd0);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk($sformatf("fullrw_drain_%0d", i), 32'(data_out), 32'(8'h60 + i));
        end
        chk("fullrw_empty", 32'(fifo_empty), 32'd1);

        // Empty with simultaneous read and write: only the write lands.
        wr_en   = 1'b1;
        data_in = 8'h77;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("emptyrw_dout",  32'(data_out),   32'h6F);
        chk("emptyrw_empty", 32'(fifo_empty), 32'd0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("emptyrw_read",  32'(data_out),   32'h77);
        chk("emptyrw_final", 32'(fifo_empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_sync_fifo_core
